// File: rtl/wb_arbiter.sv
// Writeback arbiter: two per-source FIFOs drained round-robin onto the single
// register-file write port, plus pending-write hazard lookup. Define WB_FWD_EN for fwd_a/fwd_b.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_rd,
  input  logic [31:0] s0_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_rd,
  input  logic [31:0] s1_data,
  output logic        we,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  output logic        busy_a,
  output logic        busy_b
`ifdef WB_FWD_EN
  ,
  output logic [31:0] fwd_a,
  output logic [31:0] fwd_b
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t       mem      [2][DEPTH];
  logic [AW-1:0]   wr_ptr   [2];
  logic [AW-1:0]   rd_ptr   [2];
  logic [CW-1:0]   count    [2];
  wb_entry_t       in_entry [2];
  wb_entry_t       head     [2];
  logic [1:0]      in_valid;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      full;
  logic [1:0]      empty;
  logic            rr;
  logic            rr_next;

  // Per-source status; ready depends only on occupancy, never on this cycle's pop.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_valid    = {s1_valid, s0_valid};
    in_entry[0] = '{rd: s0_rd, data: s0_data};
    in_entry[1] = '{rd: s1_rd, data: s1_data};
    full        = '0;
    empty       = '0;
    push        = '0;
    for (int s = 0; s < 2; s++) begin
      full[s]  = (count[s] == CW'(DEPTH));
      empty[s] = (count[s] == '0);
      // Writes to x0 complete the handshake but are dropped here.
      push[s]  = in_valid[s] && !full[s] && (in_entry[s].rd != 5'd0);
      head[s]  = mem[s][rd_ptr[s]];
    end
  end

  assign s0_ready = !full[0];
  assign s1_ready = !full[1];

  // Round-robin pointer: state register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr <= 1'b0;
    else     rr <= rr_next;
  end

  // Next-state and pop selection.
  always_comb begin
    pop     = '0;
    rr_next = rr;
    unique case (~empty)
      2'b01:   begin pop[0] = 1'b1; rr_next = 1'b1; end
      2'b10:   begin pop[1] = 1'b1; rr_next = 1'b0; end
      2'b11:   begin pop[rr] = 1'b1; rr_next = ~rr; end
      default: ;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + AW'(1);
        unique case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; an entry only matters while count covers it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  // Output register driving the write port; holds address/data when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we  <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (|pop) begin
      we  <= 1'b1;
      wa3 <= head[pop[1]].rd;
      wd3 <= head[pop[1]].data;
    end else begin
      we  <= 1'b0;
    end
  end

  // A register is busy while any queued entry or the in-flight write targets it.
  function automatic logic pending_hit(input logic [4:0] ra);
    logic          hit;
    logic [AW-1:0] idx;
    hit = we && (wa3 == ra);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr[s] + AW'(i);
        if (i < int'(count[s]) && mem[s][idx].rd == ra) hit = 1'b1;
      end
    end
    return hit && (ra != 5'd0);
  endfunction

  assign busy_a = pending_hit(ra_a);
  assign busy_b = pending_hit(ra_b);

`ifdef WB_FWD_EN
  // Youngest pending data: later matches overwrite earlier ones, oldest to newest,
  // so queued entries beat the in-flight write. Issue never lets both sources hold the same rd.
  function automatic logic [31:0] pending_data(input logic [4:0] ra);
    logic [31:0]   d;
    logic [AW-1:0] idx;
    d = '0;
    if (we && wa3 == ra) d = wd3;
    for (int s = 1; s >= 0; s--) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr[s] + AW'(i);
        if (i < int'(count[s]) && mem[s][idx].rd == ra) d = mem[s][idx].data;
      end
    end
    return (ra == 5'd0) ? 32'd0 : d;
  endfunction

  assign fwd_a = pending_data(ra_a);
  assign fwd_b = pending_data(ra_b);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed sequences, a vector table for
// round-robin order, and a negedge scoreboard tracking every queued write.
module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [4:0]  s0_rd, s1_rd, wa3, ra_a, ra_b;
  logic [31:0] s0_data, s1_data, wd3;
  logic        we, busy_a, busy_b;
`ifdef WB_FWD_EN
  logic [31:0] fwd_a, fwd_b;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .we(we), .wa3(wa3), .wd3(wd3),
    .ra_a(ra_a), .ra_b(ra_b), .busy_a(busy_a), .busy_b(busy_b)
`ifdef WB_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic [4:0]  exp_first;
    logic [4:0]  exp_second;
  } vec_t;

  ent_t       exp0[$];
  ent_t       exp1[$];
  logic [4:0] obs_wa3[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       mon_match;
  logic       s0_full_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic model_busy(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    foreach (exp0[i]) if (exp0[i].rd == ra) return 1'b1;
    foreach (exp1[i]) if (exp1[i].rd == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_fwd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    for (int i = exp0.size() - 1; i >= 0; i--) if (exp0[i].rd == ra) return exp0[i].data;
    for (int i = exp1.size() - 1; i >= 0; i--) if (exp1[i].rd == ra) return exp1[i].data;
    return 32'd0;
  endfunction

  // Scoreboard: queues hold accepted-but-unretired writes per source, including the one on the port.
  always @(negedge clk) begin
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end else begin
      check("busy_a", busy_a, model_busy(ra_a));
      check("busy_b", busy_b, model_busy(ra_b));
`ifdef WB_FWD_EN
      check("fwd_a", fwd_a, model_fwd(ra_a));
      check("fwd_b", fwd_b, model_fwd(ra_b));
`endif
      if (we) begin
        mon_match = 1'b0;
        if (exp0.size() > 0 && exp0[0].rd == wa3 && exp0[0].data == wd3) begin
          void'(exp0.pop_front());
          mon_match = 1'b1;
        end else if (exp1.size() > 0 && exp1[0].rd == wa3 && exp1[0].data == wd3) begin
          void'(exp1.pop_front());
          mon_match = 1'b1;
        end
        check("wb_entry_in_order", mon_match, 1'b1);
        obs_wa3.push_back(wa3);
      end
      check("s0_ready", s0_ready, exp0.size() < DEPTH);
      check("s1_ready", s1_ready, exp1.size() < DEPTH);
      if (!s0_ready) s0_full_seen = 1'b1;
      if (s0_valid && s0_ready && s0_rd != 5'd0) exp0.push_back('{rd: s0_rd, data: s0_data});
      if (s1_valid && s1_ready && s1_rd != 5'd0) exp1.push_back('{rd: s1_rd, data: s1_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold valid until a handshake at a posedge, bounded by a cycle budget.
  task automatic send(input int src, input logic [4:0] rd, input logic [31:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    if (src == 0) begin s0_valid = 1'b1; s0_rd = rd; s0_data = d; end
    else          begin s1_valid = 1'b1; s1_rd = rd; s1_data = d; end
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = (src == 0) ? s0_ready : s1_ready;
      tick();
      n++;
    end
    check($sformatf("send_accept_s%0d", src), acc, 1'b1);
    if (src == 0) s0_valid = 1'b0;
    else          s1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_rd = '0; s1_rd = '0; s0_data = '0; s1_data = '0;
    ra_a = 5'd5; ra_b = 5'd7;
    s0_full_seen = 1'b0;
    rst = 1'b1;
    repeat (2) tick();

    // Reset state
    check("rst_we", we, 1'b0);
    check("rst_wa3", wa3, 5'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_s0_ready", s0_ready, 1'b1);
    check("rst_s1_ready", s1_ready, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    rst = 1'b0;
    tick();

    // Single write: one cycle from acceptance to we
    send(0, 5'd5, 32'h1234);
    check("t1_we_accept_cycle", we, 1'b0);
    check("t1_busy_queued", busy_a, 1'b1);
    tick();
    check("t1_we", we, 1'b1);
    check("t1_wa3", wa3, 5'd5);
    check("t1_wd3", wd3, 32'h1234);
    check("t1_busy_inflight", busy_a, 1'b1);
    tick();
    check("t1_we_done", we, 1'b0);
    check("t1_busy_done", busy_a, 1'b0);
    check("t1_wa3_hold", wa3, 5'd5);

    // Write to x0 is swallowed
    ra_a = 5'd0;
    send(0, 5'd0, 32'hFFFF);
    check("x0_busy", busy_a, 1'b0);
    tick();
    check("x0_we_1", we, 1'b0);
    tick();
    check("x0_we_2", we, 1'b0);
    check("x0_wd3_hold", wd3, 32'h1234);

    // Contention from reset: strict alternation starting with s0, FIFOs fill
    do_reset();
    for (int i = 0; i < 8; i++)
      tbl[i] = '{rd0: 5'(i + 1), d0: 32'h1000 + i, rd1: 5'(i + 9), d1: 32'h2000 + i,
                 exp_first: 5'(i + 1), exp_second: 5'(i + 9)};
    obs_wa3.delete();
    s0_full_seen = 1'b0;
    ra_a = 5'd3; ra_b = 5'd12;
    fork
      for (int i = 0; i < 8; i++) send(0, tbl[i].rd0, tbl[i].d0);
      for (int i = 0; i < 8; i++) send(1, tbl[i].rd1, tbl[i].d1);
    join
    repeat (6) tick();
    check("rr_write_count", obs_wa3.size(), 16);
    for (int i = 0; i < 8; i++) begin
      if (2 * i + 1 < obs_wa3.size()) begin
        check($sformatf("rr_order_%0d_s0", i), obs_wa3[2 * i], tbl[i].exp_first);
        check($sformatf("rr_order_%0d_s1", i), obs_wa3[2 * i + 1], tbl[i].exp_second);
      end
    end
    check("s0_ready_dropped_when_full", s0_full_seen, 1'b1);

`ifdef WB_FWD_EN
    // Forwarding picks the youngest of two writes to the same register
    ra_a = 5'd7;
    send(0, 5'd7, 32'hA);
    check("fwd_first", fwd_a, 32'hA);
    send(0, 5'd7, 32'hB);
    check("fwd_youngest", fwd_a, 32'hB);
    tick();
    check("fwd_inflight", fwd_a, 32'hB);
    tick();
    check("fwd_retired_busy", busy_a, 1'b0);
    check("fwd_retired_data", fwd_a, 32'h0);
`endif

    // Reset mid-operation with three queued entries
    do_reset();
    ra_a = 5'd22; ra_b = 5'd21;
    fork
      begin send(0, 5'd20, 32'hC0); send(0, 5'd21, 32'hC1); end
      begin send(1, 5'd22, 32'hD0); send(1, 5'd23, 32'hD1); end
    join
    check("pre_rst_s1_full", s1_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_s0_ready", s0_ready, 1'b1);
    check("mid_rst_s1_ready", s1_ready, 1'b1);
    check("mid_rst_busy_a", busy_a, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_rst_no_stale_%0d", i), we, 1'b0);
    end

    // Random traffic; sources use disjoint register ranges
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(0, 5'($urandom_range(1, 15)), $urandom);
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(1, 5'($urandom_range(16, 31)), $urandom);
      end
      for (int i = 0; i < 80; i++) begin
        tick();
        ra_a = 5'($urandom_range(0, 31));
        ra_b = 5'($urandom_range(0, 31));
      end
    join
    repeat (8) tick();
    check("drain_s0_empty", exp0.size(), 0);
    check("drain_s1_empty", exp1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
